// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM transmit datapath: default sizes, sample type
// and the cyclic-prefix reader state encoding.
package ofdm_pkg;

  localparam int N_DEF      = 2048;
  localparam int CP_LEN_DEF = 144;
  localparam int CP_EXT_DEF = 16;
  localparam int DW_DEF     = 16;

  typedef logic [DW_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CP   = 2'd1,
    BODY = 2'd2
  } rd_state_t;

endpackage

// File: rtl/cp_buf_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// The ping-pong bank is carried in the address MSB by the caller.
module cp_buf_ram
  import ofdm_pkg::*;
#(
  parameter int DEPTH = 2 * N_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register is reset so dout reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ofdm_cp_insert.sv
// Transmit cyclic-prefix inserter: ping-pong buffers N-sample symbols and emits
// CP + body bursts. Optional long-CP support is enabled with `define CP_LONG_EN.
module ofdm_cp_insert
  import ofdm_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int CP_LEN = CP_LEN_DEF,
  parameter int CP_EXT = CP_EXT_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          valid_in,
  input  logic          sop_in,
  output logic          ready_in,
`ifdef CP_LONG_EN
  input  logic          long_cp_in,
`endif
  output logic [DW-1:0] dout,
  output logic          valid_out,
  output logic          sop_out,
  output logic          eop_out
);

  localparam int            AW             = $clog2(N);
  localparam logic [AW-1:0] LAST           = AW'(N - 1);
  localparam logic [AW-1:0] CP_START       = AW'(N - CP_LEN);
  localparam logic [AW-1:0] CP_START_LONG  = AW'(N - CP_LEN - CP_EXT);

  // Handshake: din is taken on any cycle with valid_in && ready_in; the output
  // side has no backpressure and streams a burst on consecutive cycles.

  logic [AW-1:0] r_wr_cnt;
  logic          r_wr_bank;
  logic [1:0]    r_full;
  logic          w_accept;
  logic [AW-1:0] w_wr_idx;
  logic          w_wr_last;
  logic [1:0]    w_set;
  logic [1:0]    w_clr;

  rd_state_t     r_state, w_state_nxt;
  logic [AW-1:0] r_rd_addr, w_addr_nxt;
  logic          r_rd_bank, w_bank_nxt;
  logic          w_rd_bank_n;
  logic          w_re, w_sop_iss, w_eop_iss;
  logic          w_long_cur, w_long_nxt;
  logic [AW-1:0] w_start_cur, w_start_nxt;
  logic          r_valid_out, r_sop_out, r_eop_out;
  logic [DW-1:0] w_ram_rdata;

  assign ready_in  = !r_full[r_wr_bank];
  assign w_accept  = valid_in && ready_in;
  // sop_in restarts the symbol at index 0, discarding any partial one.
  assign w_wr_idx  = sop_in ? '0 : r_wr_cnt;
  assign w_wr_last = w_accept && (w_wr_idx == LAST);
  assign w_set     = w_wr_last ? (2'b01 << r_wr_bank) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_full    <= 2'b00;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
      if (w_accept) begin
        if (w_wr_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt  <= w_wr_idx + 1'b1;
        end
      end
    end
  end

  assign w_rd_bank_n = ~r_rd_bank;

`ifdef CP_LONG_EN
  logic [1:0] r_long;

  always_ff @(posedge clk) begin
    if (rst)                      r_long <= 2'b00;
    else if (w_accept && sop_in)  r_long[r_wr_bank] <= long_cp_in;
  end

  assign w_long_cur = r_long[r_rd_bank];
  assign w_long_nxt = r_long[w_rd_bank_n];
`else
  assign w_long_cur = 1'b0;
  assign w_long_nxt = 1'b0;
`endif

  // The CP always ends at address N-1, so only its start depends on length.
  assign w_start_cur = w_long_cur ? CP_START_LONG : CP_START;
  assign w_start_nxt = w_long_nxt ? CP_START_LONG : CP_START;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rd_addr <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_addr <= w_addr_nxt;
      r_rd_bank <= w_bank_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_rd_addr;
    w_bank_nxt  = r_rd_bank;
    w_clr       = 2'b00;
    w_re        = 1'b0;
    w_sop_iss   = 1'b0;
    w_eop_iss   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_state_nxt = CP;
          w_addr_nxt  = w_start_cur;
        end
      end
      CP: begin
        w_re      = 1'b1;
        w_sop_iss = (r_rd_addr == w_start_cur);
        if (r_rd_addr == LAST) begin
          w_state_nxt = BODY;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt  = r_rd_addr + 1'b1;
        end
      end
      BODY: begin
        w_re = 1'b1;
        if (r_rd_addr == LAST) begin
          w_eop_iss  = 1'b1;
          w_clr      = 2'b01 << r_rd_bank;
          w_bank_nxt = w_rd_bank_n;
          // Chain straight into the next burst when its symbol is ready.
          if (r_full[w_rd_bank_n]) begin
            w_state_nxt = CP;
            w_addr_nxt  = w_start_nxt;
          end else begin
            w_state_nxt = IDLE;
            w_addr_nxt  = '0;
          end
        end else begin
          w_addr_nxt = r_rd_addr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_addr_nxt  = '0;
      end
    endcase
  end

  cp_buf_ram #(
    .DEPTH (2 * N),
    .DW    (DW),
    .AW    (AW + 1)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_accept),
    .i_waddr ({r_wr_bank, w_wr_idx}),
    .i_wdata (din),
    .i_re    (w_re),
    .i_raddr ({r_rd_bank, r_rd_addr}),
    .o_rdata (w_ram_rdata)
  );

  // Flags are delayed one cycle to line up with the registered RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_out <= 1'b0;
      r_sop_out   <= 1'b0;
      r_eop_out   <= 1'b0;
    end else begin
      r_valid_out <= w_re;
      r_sop_out   <= w_sop_iss;
      r_eop_out   <= w_eop_iss;
    end
  end

  assign dout      = w_ram_rdata;
  assign valid_out = r_valid_out;
  assign sop_out   = r_sop_out;
  assign eop_out   = r_eop_out;

endmodule

// File: tb/tb_ofdm_cp_insert.sv
// Directed bench for ofdm_cp_insert with N=16, CP_LEN=4, CP_EXT=2; expected
// output samples and flags are queued at stimulus time and popped on valid_out.
module tb_ofdm_cp_insert;

  localparam int N      = 16;
  localparam int CP_LEN = 4;
  localparam int CP_EXT = 2;
  localparam int DW     = 16;
  localparam int W      = DW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          valid_in;
  logic          sop_in;
  logic          ready_in;
  logic          long_cp_in;
  logic [DW-1:0] dout;
  logic          valid_out;
  logic          sop_out;
  logic          eop_out;

  ofdm_cp_insert #(
    .N      (N),
    .CP_LEN (CP_LEN),
    .CP_EXT (CP_EXT),
    .DW     (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .valid_in   (valid_in),
    .sop_in     (sop_in),
    .ready_in   (ready_in),
`ifdef CP_LONG_EN
    .long_cp_in (long_cp_in),
`endif
    .dout       (dout),
    .valid_out  (valid_out),
    .sop_out    (sop_out),
    .eop_out    (eop_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int          sop_cyc[$];
  int          eop_cyc[$];
  int          acc_cyc[$];
  int          run_len = 0;
  int          last_len = 0;
  int          stall_cnt = 0;

  always @(negedge clk) begin
    if (valid_out) begin
      run_len++;
      if (sop_out) sop_cyc.push_back(cyc);
      if (eop_out) eop_cyc.push_back(cyc);
      checks++;
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      assert ({sop_out, eop_out, dout} === mon_exp) else begin
        errors++;
        $error("FAIL sb_sample: observed sop=%0b eop=%0b dout=%0d expected sop=%0b eop=%0b dout=%0d",
               sop_out, eop_out, dout, mon_exp[W-1], mon_exp[W-2], mon_exp[DW-1:0]);
      end
    end else if (run_len != 0) begin
      last_len = run_len;
      run_len  = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic fail_timeout(input string tag, input int waited);
    checks++;
    errors++;
    $error("FAIL %s: waited %0d cycles without the expected event", tag, waited);
  endtask

  // ---------------- driver ----------------
  logic [DW-1:0] st_d[$];
  bit            st_sop[$];
  bit            st_long[$];

  task automatic add_sym(input int base, input int cnt, input bit lng);
    for (int i = 0; i < cnt; i++) begin
      st_d.push_back(DW'(base + i));
      st_sop.push_back(i == 0);
      st_long.push_back(lng);
    end
  endtask

  task automatic push_exp(input int base, input int cpl);
    logic [W-1:0] e;
    for (int i = N - cpl; i < N; i++) begin
      e = {(i == N - cpl), 1'b0, DW'(base + i)};
      exp_q.push_back(e);
    end
    for (int i = 0; i < N; i++) begin
      e = {1'b0, (i == N - 1), DW'(base + i)};
      exp_q.push_back(e);
    end
  endtask

  task automatic run_stim();
    int wait_n = 0;
    acc_cyc.delete();
    stall_cnt = 0;
    while (st_d.size() > 0) begin
      @(posedge clk); #1;
      valid_in   = 1'b1;
      din        = st_d[0];
      sop_in     = st_sop[0];
      long_cp_in = st_long[0];
      if (ready_in) begin
        acc_cyc.push_back(cyc + 1);
        void'(st_d.pop_front());
        void'(st_sop.pop_front());
        void'(st_long.pop_front());
        wait_n = 0;
      end else begin
        stall_cnt++;
        wait_n++;
        if (wait_n > 200) begin
          fail_timeout("ready_timeout", wait_n);
          st_d.delete(); st_sop.delete(); st_long.delete();
        end
      end
    end
    @(posedge clk); #1;
    valid_in   = 1'b0;
    sop_in     = 1'b0;
    long_cp_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || valid_out) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) fail_timeout("drain_timeout", n);
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    sop_cyc.delete();
    eop_cyc.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; din = '0; valid_in = 1'b0; sop_in = 1'b0; long_cp_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_sop_out",   sop_out,   1'b0);
    chk("rst_eop_out",   eop_out,   1'b0);
    chk("rst_dout",      dout,      '0);
    chk("rst_ready_in",  ready_in,  1'b1);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // single symbol
    clear_logs();
    add_sym(0, N, 1'b0);
    push_exp(0, CP_LEN);
    run_stim();
    drain();
    chk("t1_burst_len", last_len, N + CP_LEN);
    chk("t1_latency",   sop_cyc[0], acc_cyc[N-1] + 2);
    chk("t1_eop_pos",   eop_cyc[0], sop_cyc[0] + N + CP_LEN - 1);

    // two symbols back-to-back
    clear_logs();
    add_sym(0, N, 1'b0);
    add_sym(100, N, 1'b0);
    push_exp(0, CP_LEN);
    push_exp(100, CP_LEN);
    run_stim();
    drain();
    chk("t2_burst_len", last_len, 2 * (N + CP_LEN));
    chk("t2_sop_count", sop_cyc.size(), 2);
    chk("t2_gapless",   sop_cyc[1], eop_cyc[0] + 1);

    // three symbols: writer stalls on both banks full
    clear_logs();
    add_sym(0, N, 1'b0);
    add_sym(100, N, 1'b0);
    add_sym(200, N, 1'b0);
    push_exp(0, CP_LEN);
    push_exp(100, CP_LEN);
    push_exp(200, CP_LEN);
    run_stim();
    drain();
    chk("t3_32nd_accept", acc_cyc[2*N-1], acc_cyc[N-1] + N);
    chk("t3_stall_cycles", stall_cnt, CP_LEN + 1);
    chk("t3_ready_rise",  acc_cyc[2*N], acc_cyc[N-1] + N + CP_LEN + 2);
    chk("t3_burst_len",   last_len, 3 * (N + CP_LEN));

    // sop_in mid-symbol discards the partial symbol
    clear_logs();
    add_sym(0, 7, 1'b0);
    add_sym(50, N, 1'b0);
    push_exp(50, CP_LEN);
    run_stim();
    drain();
    chk("t4_burst_len", last_len, N + CP_LEN);
    chk("t4_sop_count", sop_cyc.size(), 1);

    // reset during the CP of a burst
    clear_logs();
    add_sym(0, N, 1'b0);
    push_exp(0, CP_LEN);
    run_stim();
    begin
      int n = 0;
      while (!valid_out && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 50) fail_timeout("t5_first_valid", n);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_valid_out", valid_out, 1'b0);
    chk("t5_rst_sop_out",   sop_out,   1'b0);
    chk("t5_rst_dout",      dout,      '0);
    chk("t5_rst_ready_in",  ready_in,  1'b1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("t5_no_output_after_rst", valid_out, 1'b0);
    clear_logs();
    add_sym(0, N, 1'b0);
    push_exp(0, CP_LEN);
    run_stim();
    drain();
    chk("t5_burst_len", last_len, N + CP_LEN);
    chk("t5_latency",   sop_cyc[0], acc_cyc[N-1] + 2);

`ifdef CP_LONG_EN
    // long-CP symbol followed by a normal one
    clear_logs();
    add_sym(0, N, 1'b1);
    push_exp(0, CP_LEN + CP_EXT);
    run_stim();
    drain();
    chk("t6_long_len", last_len, N + CP_LEN + CP_EXT);
    clear_logs();
    add_sym(0, N, 1'b0);
    push_exp(0, CP_LEN);
    run_stim();
    drain();
    chk("t6_normal_len", last_len, N + CP_LEN);
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
